// File: rtl/sha_pkg.sv
// Shared SHA types, round counts and sigma/rotate helpers for the hash datapath.
package sha;

  typedef enum logic [2:0] {
    MODE_SHA1   = 3'd0,
    MODE_SHA224 = 3'd1,
    MODE_SHA256 = 3'd2,
    MODE_SHA384 = 3'd3,
    MODE_SHA512 = 3'd4
  } mode_t;

  typedef logic [63:0] word_t;

  localparam int unsigned ROUNDS_SHA1   = 80;
  localparam int unsigned ROUNDS_SHA256 = 64;
  localparam int unsigned ROUNDS_SHA512 = 80;

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [31:0] rotl1_32(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

  // Compression-round (uppercase) sigmas
  function automatic logic [31:0] sigma0_32(input logic [31:0] x);
    return rotr32(x, 2) ^ rotr32(x, 13) ^ rotr32(x, 22);
  endfunction

  function automatic logic [31:0] sigma1_32(input logic [31:0] x);
    return rotr32(x, 6) ^ rotr32(x, 11) ^ rotr32(x, 25);
  endfunction

  function automatic logic [63:0] sigma0_64(input logic [63:0] x);
    return rotr64(x, 28) ^ rotr64(x, 34) ^ rotr64(x, 39);
  endfunction

  function automatic logic [63:0] sigma1_64(input logic [63:0] x);
    return rotr64(x, 14) ^ rotr64(x, 18) ^ rotr64(x, 41);
  endfunction

  // Message-schedule (lowercase) sigmas
  function automatic logic [31:0] s0_32(input logic [31:0] x);
    return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1_32(input logic [31:0] x);
    return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [63:0] s0_64(input logic [63:0] x);
    return rotr64(x, 1) ^ rotr64(x, 8) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] s1_64(input logic [63:0] x);
    return rotr64(x, 19) ^ rotr64(x, 61) ^ (x >> 6);
  endfunction

  function automatic logic is_sha1(input mode_t m);
    return m == MODE_SHA1;
  endfunction

  function automatic logic is_64(input mode_t m);
    return (m == MODE_SHA384) || (m == MODE_SHA512);
  endfunction

  function automatic logic [6:0] rounds(input mode_t m);
    logic [6:0] r;
    case (m)
      MODE_SHA224, MODE_SHA256: r = 7'(ROUNDS_SHA256);
      MODE_SHA384, MODE_SHA512: r = 7'(ROUNDS_SHA512);
      default:                  r = 7'(ROUNDS_SHA1);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sha_schedule_calc.sv
// Combinational next schedule word from four buffer taps.
// Taps: w_a = W[n-2] (sha1: n-3), w_b = W[n-7] (n-8), w_c = W[n-15] (n-14), w_d = W[n-16].
module sha_schedule_calc
  import sha::*;
(
  input  mode_t mode,
  input  word_t w_a,
  input  word_t w_b,
  input  word_t w_c,
  input  word_t w_d,
  output word_t w_next
);

  always_comb begin
    w_next = '0;
    if (is_sha1(mode)) begin
      w_next[31:0] = rotl1_32(w_a[31:0] ^ w_b[31:0] ^ w_c[31:0] ^ w_d[31:0]);
    end else if (is_64(mode)) begin
      w_next = s1_64(w_a) + w_b + s0_64(w_c) + w_d;
    end else begin
      w_next[31:0] = s1_32(w_a[31:0]) + w_b[31:0] + s0_32(w_c[31:0]) + w_d[31:0];
    end
  end

endmodule

// File: rtl/sha_schedule.sv
// SHA message-schedule stage: accepts a 16-word block and streams W_t with round index
// through a 16-slot circular buffer where each generated word replaces W[t-16].
module sha_schedule
  import sha::*;
#(
  parameter int WORD_W = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  mode_t                 mode,
  input  logic                  block_valid,
  output logic                  block_ready,
  input  logic [16*WORD_W-1:0]  block,
  input  logic                  abort,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [WORD_W-1:0]     w_out,
  output logic [6:0]            round,
  output logic                  last,
  output logic                  done
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state_q, state_d;
  mode_t       mode_q, mode_d;
  word_t       buf_q [16];
  word_t       buf_d [16];
  word_t       lane_w [16];
  word_t       w_q, w_d;
  logic [6:0]  round_q, round_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;

  logic [6:0]  n_idx;
  logic [3:0]  slot;
  logic        last_round;
  word_t       tap_a, tap_b, tap_c, tap_d;
  word_t       calc_w, next_w;

  assign n_idx      = round_q + 7'd1;
  assign slot       = n_idx[3:0];
  assign last_round = (round_q == rounds(mode_q) - 7'd1);

  // sha1 and sha2 read different taps; W[n-16] shares the slot being overwritten
  always_comb begin
    tap_a = is_sha1(mode_q) ? buf_q[slot - 4'd3]  : buf_q[slot - 4'd2];
    tap_b = is_sha1(mode_q) ? buf_q[slot - 4'd8]  : buf_q[slot - 4'd7];
    tap_c = is_sha1(mode_q) ? buf_q[slot - 4'd14] : buf_q[slot - 4'd15];
    tap_d = buf_q[slot];
  end

  sha_schedule_calc u_calc (
    .mode   (mode_q),
    .w_a    (tap_a),
    .w_b    (tap_b),
    .w_c    (tap_c),
    .w_d    (tap_d),
    .w_next (calc_w)
  );

  assign next_w = (n_idx < 7'd16) ? buf_q[slot] : calc_w;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      lane_w[i] = block[i*WORD_W +: WORD_W];
      if (!is_64(mode)) lane_w[i][63:32] = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    buf_d   = buf_q;
    w_d     = w_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (block_valid && ready_q) begin
          mode_d  = mode;
          buf_d   = lane_w;
          w_d     = lane_w[0];
          round_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (w_ready) begin
          if (last_round) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            w_d     = next_w;
            round_d = n_idx;
            if (n_idx >= 7'd16) buf_d[slot] = next_w;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_SHA256;
      for (int i = 0; i < 16; i++) buf_q[i] <= '0;
      w_q     <= '0;
      round_q <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      buf_q   <= buf_d;
      w_q     <= w_d;
      round_q <= round_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign block_ready = ready_q;
  assign w_valid     = (state_q == S_RUN);
  assign w_out       = w_q;
  assign round       = round_q;
  assign last        = w_valid && last_round;
  assign done        = done_q;

endmodule

// File: tb/tb_sha_schedule.sv
// Directed bench for sha_schedule with a scoreboard fed by an independent schedule model.
module tb_sha_schedule;
  import sha::*;

  logic          clk = 1'b0;
  logic          rstn;
  mode_t         mode;
  logic          block_valid;
  logic          block_ready;
  logic [1023:0] block;
  logic          abort;
  logic          w_valid;
  logic          w_ready;
  logic [63:0]   w_out;
  logic [6:0]    round;
  logic          last;
  logic          done;

  sha_schedule #(.WORD_W(64)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .mode        (mode),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block       (block),
    .abort       (abort),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_out       (w_out),
    .round       (round),
    .last        (last),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] w;
    logic [6:0]  r;
    logic        l;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] got [80];
  logic [63:0] ref256 [80];
  int          n_got;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Full 80-entry schedule computed directly from the textbook recurrences
  task automatic push_model(input mode_t m, input logic [1023:0] b);
    logic [63:0] w [80];
    logic [31:0] x, a32, c32;
    logic [63:0] a64, c64;
    bit          w64, s1;
    int          nr;
    s1  = (m == MODE_SHA1);
    w64 = (m == MODE_SHA384) || (m == MODE_SHA512);
    nr  = (m == MODE_SHA224 || m == MODE_SHA256) ? 64 : 80;
    for (int t = 0; t < 16; t++) begin
      w[t] = b[t*64 +: 64];
      if (!w64) w[t][63:32] = 32'h0;
    end
    for (int t = 16; t < 80; t++) begin
      if (s1) begin
        x    = w[t-3][31:0] ^ w[t-8][31:0] ^ w[t-14][31:0] ^ w[t-16][31:0];
        w[t] = {32'h0, x[30:0], x[31]};
      end else if (w64) begin
        a64  = w[t-2];
        c64  = w[t-15];
        w[t] = (ror64(a64, 19) ^ ror64(a64, 61) ^ (a64 >> 6)) + w[t-7]
             + (ror64(c64, 1) ^ ror64(c64, 8) ^ (c64 >> 7)) + w[t-16];
      end else begin
        a32  = w[t-2][31:0];
        c32  = w[t-15][31:0];
        x    = (ror32(a32, 17) ^ ror32(a32, 19) ^ (a32 >> 10)) + w[t-7][31:0]
             + (ror32(c32, 7) ^ ror32(c32, 18) ^ (c32 >> 3)) + w[t-16][31:0];
        w[t] = {32'h0, x};
      end
    end
    for (int t = 0; t < nr; t++) sb.push_back('{w: w[t], r: 7'(t), l: (t == nr - 1)});
  endtask

  function automatic logic [1023:0] abc_block(input bit w64, input bit garbage);
    logic [1023:0] b;
    b = '0;
    if (garbage) for (int i = 0; i < 16; i++) b[i*64+32 +: 32] = $urandom;
    if (w64) b[63:0] = 64'h6162638000000000;
    else     b[31:0] = 32'h61626380;
    b[15*64 +: 32] = 32'h18;
    return b;
  endfunction

  function automatic logic [1023:0] rand_block();
    logic [1023:0] b;
    for (int i = 0; i < 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle (or after abort/reset).
  // rmode 0: w_ready held high; 1: pseudo-random 1,0,0,1 style stalls.
  task automatic run_block(input mode_t m, input logic [1023:0] b, input int rmode,
                           input int abort_at, input int reset_at);
    exp_t e;
    bit   fin;
    logic rdy;
    chk("accept_ready", block_ready, 1'b1);
    block_valid = 1'b1;
    mode        = m;
    block       = b;
    push_model(m, b);
    n_got = 0;
    for (int t = 0; t < 80; t++) got[t] = 'x;
    @(negedge clk);
    block_valid = 1'b0;
    mode        = (m == MODE_SHA1) ? MODE_SHA512 : MODE_SHA1;
    block       = rand_block();
    chk("w0_latency", w_valid, 1'b1);
    chk("done_low_in_block", done, 1'b0);
    fin = 0;
    for (int cyc = 0; cyc < 800 && !fin && sb.size() > 0; cyc++) begin
      e = sb[0];
      if (reset_at >= 0 && int'(e.r) == reset_at) begin
        w_ready = 1'b0;
        rstn    = 1'b0;
        #1;
        chk("rst_mid_block_ready", block_ready, 1'b0);
        chk("rst_mid_w_valid", w_valid, 1'b0);
        chk("rst_mid_w_out", w_out, 64'h0);
        chk("rst_mid_round", round, 7'd0);
        chk("rst_mid_last", last, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        sb.delete();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", block_ready, 1'b1);
        return;
      end
      if (abort_at >= 0 && int'(e.r) == abort_at) begin
        chk("abort_round", round, e.r);
        abort   = 1'b1;
        w_ready = 1'b1;
        @(negedge clk);
        abort   = 1'b0;
        w_ready = 1'b0;
        chk("abort_w_valid", w_valid, 1'b0);
        chk("abort_no_done", done, 1'b0);
        chk("abort_ready", block_ready, 1'b1);
        sb.delete();
        return;
      end
      chk("w_valid_run", w_valid, 1'b1);
      chk("last_flag", last, e.l);
      if (rmode == 0) rdy = 1'b1;
      else            rdy = (cyc % 4 == 0 || cyc % 4 == 3) ? 1'b1 : 1'($urandom_range(0, 1));
      w_ready = rdy;
      if (rdy) begin
        void'(sb.pop_front());
        chk("w_out", w_out, e.w);
        chk("round", round, e.r);
        got[e.r] = w_out;
        n_got++;
        if (e.l) fin = 1;
      end
      @(negedge clk);
    end
    w_ready = 1'b0;
    chk("block_complete", fin, 1'b1);
    chk("done_pulse", done, 1'b1);
    chk("done_ready", block_ready, 1'b1);
    chk("done_w_valid", w_valid, 1'b0);
  endtask

  initial begin
    logic [31:0] upper;
    bit          same;
    rstn        = 1'b0;
    mode        = MODE_SHA256;
    block_valid = 1'b0;
    block       = '0;
    abort       = 1'b0;
    w_ready     = 1'b0;
    #12;
    chk("rst_block_ready", block_ready, 1'b0);
    chk("rst_w_valid", w_valid, 1'b0);
    chk("rst_w_out", w_out, 64'h0);
    chk("rst_round", round, 7'd0);
    chk("rst_last", last, 1'b0);
    chk("rst_done", done, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", block_ready, 1'b1);

    // sha256 "abc", w_ready high
    run_block(MODE_SHA256, abc_block(0, 0), 0, -1, -1);
    chk("sha256_w16", got[16], 64'h0000000061626380);
    chk("sha256_w17", got[17], 64'h00000000000F0000);
    chk("sha256_count", n_got, 64);
    for (int t = 0; t < 80; t++) ref256[t] = got[t];

    // sha512 "abc", accepted in the done cycle of the previous block
    run_block(MODE_SHA512, abc_block(1, 0), 0, -1, -1);
    chk("sha512_w16", got[16], 64'h6162638000000000);
    chk("sha512_w17", got[17], 64'h00030000000000C0);
    chk("sha512_count", n_got, 80);

    // sha1 "abc" with junk in the unused upper lane halves
    run_block(MODE_SHA1, abc_block(0, 1), 0, -1, -1);
    chk("sha1_w16", got[16], 64'h00000000C2C4C700);
    chk("sha1_count", n_got, 80);
    upper = '0;
    for (int t = 0; t < 80; t++) upper |= got[t][63:32];
    chk("sha1_upper_zero", upper, 32'h0);

    // sha256 "abc" with stalls must reproduce the unstalled stream
    run_block(MODE_SHA256, abc_block(0, 1), 1, -1, -1);
    same = 1;
    for (int t = 0; t < 64; t++) if (got[t] !== ref256[t]) same = 0;
    chk("stall_stream_equal", same, 1'b1);

    // abort at round 20, then a fresh block
    run_block(MODE_SHA512, rand_block(), 0, 20, -1);
    @(negedge clk);
    chk("idle_abort_ready", block_ready, 1'b1);
    run_block(MODE_SHA256, rand_block(), 1, -1, -1);
    chk("post_abort_w0", got[0][31:0], block[31:0] ^ block[31:0] ^ got[0][31:0]);

    // reset mid-block, then back-to-back sha256 -> sha384
    run_block(MODE_SHA256, abc_block(0, 0), 0, -1, 40);
    run_block(MODE_SHA256, rand_block(), 0, -1, -1);
    run_block(MODE_SHA384, rand_block(), 1, -1, -1);
    chk("sha384_count", n_got, 80);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sha_schedule.md
Name: sha_schedule

Overview:
- Message-schedule stage that sits directly upstream of the compression round stage.
- Accepts one 16-word padded message block and streams the per-round schedule word W_t, one per accepted beat, together with the round index.
- Supports sha1, sha224/256 (32-bit words) and sha384/512 (64-bit words).
- Uses a 16-entry circular buffer, so generated words overwrite the oldest slot.

Parameters:
- WORD_W, 64, storage width of each schedule word; fixed at 64. 32-bit modes use bits [31:0].

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- mode  input  sha::mode_t  algorithm select; sampled only at block accept
- block_valid  input  1  a block is presented
- block_ready  output  1  stage can accept a block
- block  input  16*WORD_W  message words; word 0 in the lowest lane; 32-bit modes use lane bits [31:0]
- abort  input  1  synchronous cancel of the current block
- w_valid  output  1  w_out/round are valid
- w_ready  input  1  downstream consumes the current word (drives the round stage enable)
- w_out  output  WORD_W  W_t
- round  output  7  t, 0..79
- last  output  1  asserted with the final round's word
- done  output  1  one-cycle pulse after the final word is consumed

Behaviour:
- Reset (async, rstn low): state IDLE, buffer cleared, block_ready=0 during reset then 1, w_valid=0, w_out=0, round=0, last=0, done=0.
- States and transitions:
  - IDLE: block_ready=1. On block_valid&&block_ready, latch mode into mode_q, write all 16 words to the buffer, load w_out=word0 and round=0, go to RUN.
  - RUN: block_ready=0, w_valid=1. On w_valid&&w_ready:
    - if round==N-1, go to IDLE and pulse done next cycle;
    - otherwise register W_{t+1} into w_out and round+1.
  - Without w_ready, w_out and round hold (stall of any length).
- N = 64 for sha224/256; N = 80 for sha1/384/512.
- Latency: first W0 is valid the cycle after the block handshake. Sustained throughput is one word per cycle with w_ready tied high.
- Word generation for next index n = t+1:
  - n<16: buffer[n].
  - n>=16, slot s=n mod 16, with buffer[(n-k) mod 16] for k=2,3,7,8,14,15,16. The generated word is written to buffer[s] in the same cycle it is registered into w_out.
  - sha224/256: W = s1_32(W[n-2]) + W[n-7] + s0_32(W[n-15]) + W[n-16] mod 2^32.
    - s0_32 = rotr7^rotr18^shr3
    - s1_32 = rotr17^rotr19^shr10
    - w_out[63:32] = 0
  - sha384/512: same form mod 2^64.
    - s0_64 = rotr1^rotr8^shr7
    - s1_64 = rotr19^rotr61^shr6
  - sha1: W = rotl1(W[n-3]^W[n-8]^W[n-14]^W[n-16]), 32-bit, upper half 0.
- Pointer: 4-bit slot index wraps 15->0. The round counter never wraps; it resets to 0 per block.
- last = w_valid && round==N-1.
- done goes high for exactly one cycle, in the cycle after the last handshake, simultaneously with block_ready=1. A new block may be accepted in that same cycle.
- abort (RUN): next cycle IDLE, w_valid=0, no done. In IDLE, abort has no effect. If abort is high in the same cycle as a w_ready handshake, abort wins.
- mode changes while RUN are ignored (mode_q used).
- Reset asserted mid-block: immediate return to reset values; the partial block is discarded.

Decomposition:
- sha package:
  - mode_t (existing)
  - word_t (existing)
  - lowercase-sigma functions s0_32, s1_32, s0_64, s1_64, alongside the existing sigma0_32/sigma1_32/sigma0_64/sigma1_64
  - rotl1_32
  - round-count constants ROUNDS_SHA1=80, ROUNDS_SHA256=64, ROUNDS_SHA512=80
- One sub-module: sha_schedule_calc, a combinational next-word function of mode_q and the four tap words.
- Buffer, pointer and FSM stay in sha_schedule.

Test Plan:
- sha256, "abc" padded block (W0=0x61626380, W15=0x00000018, w_ready=1) -> W0..W15 echo the block, W16=0x61626380, W17=0x000F0000; last at round 63; done one cycle later.
- sha512, "abc" block (W0=0x6162638000000000, W15=0x18) -> W16=0x6162638000000000, W17=0x00030000000000C0; 80 words; last at round 79.
- sha1, "abc" block (W0=0x61626380, W15=0x18) -> W16=0xC2C4C700; upper 32 bits of w_out always 0; 80 words.
- sha256 with w_ready toggling 1,0,0,1 pseudo-randomly -> word stream identical to the w_ready=1 run; round advances only on handshake.
- abort asserted at round 20 -> w_valid=0 next cycle, no done, block_ready=1. The next block produces a correct W0 and round=0.
- rstn pulsed low at round 40; then a sha384 block presented during the done cycle of a previous sha256 block -> all outputs return to reset values; the back-to-back accept occurs with no idle cycle; mode_q=sha384 is used, giving 80 rounds.
